hwpe_stream_demux_sched: RTL
============================

Name: hwpe_stream_demux_sched

Overview:
Sequencer for hwpe_stream_demux_static. It drives the demux select so that one input stream is split into per-output bursts of programmed length, cycling round-robin over the outputs for a programmed number of rounds. It counts handshakes on the demux push side and changes the select only between beats, which guarantees the "no transaction in flight" rule of the static demux. It sits beside the demux inside a streamer or engine datapath.

Parameters:
NB_OUT_STREAMS, 2, number of demux outputs scheduled (>=2)
CNT_WIDTH, 16, width of the beat-length and round counters

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous soft clear; state returns to IDLE
start_i  input  1  start pulse; sampled in IDLE only
len_i  input  NB_OUT_STREAMS x CNT_WIDTH  beats per burst for each output; 0 = output skipped
nb_rounds_i  input  CNT_WIDTH  number of full round-robin passes; 0 = no transfer
push_valid_i  input  1  copy of demux push_i.valid
push_ready_i  input  1  copy of demux push_i.ready
sel_o  output  $clog2(NB_OUT_STREAMS)  demux sel_i
stream_en_o  output  1  high only in RUN; parent ANDs it into push valid/ready upstream
busy_o  output  1  high in RUN
done_o  output  1  one-cycle pulse at job end

Behaviour:
- Reset (rst_ni=0) and clear_i: state=IDLE, sel_o=0, beat_cnt=0, round_cnt=0, stream_en_o=0, busy_o=0, done_o=0. clear_i has priority over every other event, including a handshake in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start_i, latch len_i and nb_rounds_i.
  - If nb_rounds_i==0 or all len==0, go to DONE.
  - Otherwise go to RUN with sel_o = lowest index whose len!=0.
- RUN: handshake hs = push_valid_i & push_ready_i.
  - On hs, beat_cnt increments.
  - On hs with beat_cnt==len[sel]-1: beat_cnt<=0 and sel_o<=next index after sel with len!=0, searching cyclically.
  - If that search wraps (next<=sel), round_cnt increments.
  - If the wrap happens with round_cnt==nb_rounds-1, go to DONE instead; sel_o holds its value.
- Select timing: sel_o changes in the cycle after the final beat's handshake, never combinationally with hs.
- Single active output: when exactly one len!=0, sel_o stays constant and only round_cnt advances.
- DONE: done_o=1 for exactly one cycle, then IDLE. sel_o keeps its last value until the next start.
- start_i in RUN or DONE is ignored.
- Config inputs are ignored outside IDLE.
- Counters compare with equality; no overflow is possible because len and nb_rounds are at most 2^CNT_WIDTH-1.
- Beats without a handshake (valid without ready, or ready without valid) do not count.

Decomposition:
- hwpe_stream_package gains:
  - typedef enum hwpe_stream_demux_sched_state_t {IDLE, RUN, DONE}
  - struct hwpe_stream_demux_sched_ctrl_t {start, nb_rounds}
  - struct hwpe_stream_demux_sched_flags_t {busy, done, sel}
- One sub-module is natural: hwpe_stream_demux_sched_next. It is a combinational cyclic priority finder. Inputs: current sel and the nonzero-length mask. Outputs: next index and wrap flag. It is reused for the IDLE first-index search by passing sel=NB_OUT_STREAMS-1.

Test Plan:
- N=2, len={3,2}, rounds=2, continuous valid/ready → sel_o sequence 0,0,0,1,1,0,0,0,1,1; done_o pulses one cycle after the 10th handshake; 10 handshakes total.
- N=4, len={2,0,1,0}, rounds=1 → sel_o 0,0,2; outputs 1 and 3 never selected; done after 3 beats.
- Same as the first scenario with random ready backpressure (50%) → sel_o changes only in the cycle after a counted last-beat handshake; sel_o is stable while valid&!ready.
- rounds=0, or all len=0, with start_i → IDLE→DONE→IDLE; done_o pulses once; busy_o never high; sel_o stays 0.
- clear_i asserted mid-RUN (after 2 of 5 beats), simultaneous with a handshake → next cycle IDLE, counters 0, sel_o=0, no done_o; a new start runs the full job.
- Async reset asserted mid-RUN (rst_ni low between clock edges) → all outputs go to reset values immediately; start_i during RUN is ignored and does not restart the counters.

Source files
------------

// File: rtl/hwpe_stream_demux_sched_pkg.sv
// hwpe_stream_demux_sched_pkg: shared types for the demux burst sequencer
package hwpe_stream_demux_sched_pkg;

    localparam int unsigned MAX_CNT_WIDTH = 32;
    localparam int unsigned MAX_SEL_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} hwpe_stream_demux_sched_state_t;

    typedef struct packed {
        logic                     start;
        logic [MAX_CNT_WIDTH-1:0] nb_rounds;
    } hwpe_stream_demux_sched_ctrl_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [MAX_SEL_WIDTH-1:0] sel;
    } hwpe_stream_demux_sched_flags_t;

endpackage

// File: rtl/hwpe_stream_demux_sched_next.sv
// hwpe_stream_demux_sched_next: cyclic priority finder for the next enabled output after sel
module hwpe_stream_demux_sched_next
    import hwpe_stream_demux_sched_pkg::*;
#(
    parameter int unsigned NB_OUT_STREAMS = 2,
    localparam int unsigned SEL_W = $clog2(NB_OUT_STREAMS)
) (
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NB_OUT_STREAMS-1:0] mask_i,
    output logic [SEL_W-1:0]          next_o,
    output logic                      wrap_o
);

    // scan from the farthest candidate down so the nearest enabled index after sel wins
    always_comb begin
        next_o = sel_i;
        for (int k = NB_OUT_STREAMS; k >= 1; k--) begin
            if (mask_i[(int'(sel_i) + k) % NB_OUT_STREAMS])
                next_o = SEL_W'((int'(sel_i) + k) % NB_OUT_STREAMS);
        end
        wrap_o = next_o <= sel_i;
    end

endmodule

// File: rtl/hwpe_stream_demux_sched.sv
// hwpe_stream_demux_sched: round-robin burst sequencer driving a static demux select
module hwpe_stream_demux_sched
    import hwpe_stream_demux_sched_pkg::*;
#(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned CNT_WIDTH      = 16,
    localparam int unsigned SEL_W = $clog2(NB_OUT_STREAMS)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     clear_i,
    input  logic                                     start_i,
    input  logic [NB_OUT_STREAMS-1:0][CNT_WIDTH-1:0] len_i,
    input  logic [CNT_WIDTH-1:0]                     nb_rounds_i,
    input  logic                                     push_valid_i,
    input  logic                                     push_ready_i,
    output logic [SEL_W-1:0]                         sel_o,
    output logic                                     stream_en_o,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    hwpe_stream_demux_sched_state_t            state_q, state_d;
    logic [SEL_W-1:0]                          sel_q, sel_d, next;
    logic [CNT_WIDTH-1:0]                      beat_q, beat_d, round_q, round_d, rounds_q, rounds_d;
    logic [NB_OUT_STREAMS-1:0][CNT_WIDTH-1:0]  len_q, len_d;
    logic [NB_OUT_STREAMS-1:0]                 mask;
    logic                                      wrap, hs;

    assign hs = push_valid_i & push_ready_i;

    // enabled outputs come from the live config in IDLE and from the latched one otherwise
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB_OUT_STREAMS; i++)
            mask[i] = (state_q == IDLE ? len_i[i] : len_q[i]) != '0;
    end

    hwpe_stream_demux_sched_next #(.NB_OUT_STREAMS(NB_OUT_STREAMS)) i_next (
        .sel_i  (state_q == IDLE ? SEL_W'(NB_OUT_STREAMS-1) : sel_q),
        .mask_i (mask),
        .next_o (next),
        .wrap_o (wrap)
    );

    // next-state: select only moves after a counted last beat; clear overrides everything
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        beat_d   = beat_q;
        round_d  = round_q;
        len_d    = len_q;
        rounds_d = rounds_q;
        case (state_q)
            IDLE: if (start_i) begin
                len_d    = len_i;
                rounds_d = nb_rounds_i;
                beat_d   = '0;
                round_d  = '0;
                if (nb_rounds_i == '0 || mask == '0) state_d = DONE;
                else begin
                    state_d = RUN;
                    sel_d   = next;
                end
            end
            RUN: if (hs) begin
                if (beat_q == len_q[sel_q] - ONE) begin
                    beat_d = '0;
                    if (wrap && round_q == rounds_q - ONE) state_d = DONE;
                    else begin
                        sel_d   = next;
                        round_d = wrap ? round_q + ONE : round_q;
                    end
                end else beat_d = beat_q + ONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            sel_d   = '0;
            beat_d  = '0;
            round_d = '0;
        end
    end

    // state and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            beat_q   <= '0;
            round_q  <= '0;
            len_q    <= '0;
            rounds_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            beat_q   <= beat_d;
            round_q  <= round_d;
            len_q    <= len_d;
            rounds_q <= rounds_d;
        end
    end

    assign sel_o       = sel_q;
    assign stream_en_o = state_q == RUN;
    assign busy_o      = state_q == RUN;
    assign done_o      = state_q == DONE;

endmodule
